bsr_seg: RTL and testbench
==========================

BSR_SEG -- requirements
Module: bsr_seg

Interface
REQ-001 Parameter WIDTH, default 32, total boundary cells; SHALL be a multiple of SEGS.
REQ-002 Parameter SEGS, default 4, number of equal segments, each SEG_W = WIDTH/SEGS cells wide.
REQ-003 Reset is synchronous and active-high; one clock.
REQ-004 ICLK  input  1  sole clock, all state on rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 p_data_in  input  WIDTH  parallel system-side data.
REQ-007 p_data_out  output  WIDTH  parallel pin-side data.
REQ-008 s_data_in  input  1  serial scan input, enters cell 0.
REQ-009 s_data_out  output  1  serial scan output from last segment.
REQ-010 mode  input  1  1 = drive update register to pins, 0 = transparent.
REQ-011 capture_dr  input  1  one-cycle capture strobe.
REQ-012 shift_dr  input  1  shift enable, one bit per cycle.
REQ-013 update_dr  input  1  one-cycle update strobe.
REQ-014 seg_en  input  SEGS  segment enable request, bit k for segment k (cells k*SEG_W .. k*SEG_W+SEG_W-1).
REQ-015 chain_len  output  16  current scan chain length in bits.
REQ-016 shift_cnt  output  16  shifts since last capture.

Function
REQ-017 Block SHALL hold shift register sr[WIDTH], update register ur[WIDTH], per-segment bypass flop byp[SEGS], segment config register seg_cfg[SEGS], counter shift_cnt.
REQ-018 Strobe priority: capture_dr > shift_dr > update_dr; only the highest asserted strobe acts in a cycle, others ignored.
REQ-019 Capture: seg_cfg <= seg_en; for segments with new seg_en bit 1, sr segment <= p_data_in segment; for bit 0, byp[k] <= 0 and sr segment holds; shift_cnt <= 0.
REQ-020 Topology SHALL change only on capture; seg_en changes at other times have no effect.
REQ-021 Shift: chain runs s_data_in -> segment 0 -> ... -> segment SEGS-1 -> s_data_out; enabled segment shifts toward its MSB (bit 0 takes segment input, MSB is segment output); disabled segment is single flop byp[k].
REQ-022 s_data_out SHALL be combinational from flops: sr[WIDTH-1] if seg_cfg[SEGS-1]=1, else byp[SEGS-1]; no extra latency.
REQ-023 Update: ur segment <= sr segment for enabled segments only; ur of disabled segments holds.
REQ-024 p_data_out = mode ? ur : p_data_in, combinational, per bit.
REQ-025 chain_len = SEG_W x (ones in seg_cfg) + (zeros in seg_cfg), combinational from seg_cfg.
REQ-026 shift_cnt increments by 1 per shift cycle, saturates at 16'hFFFF, no wrap.
REQ-027 Capture and shift asserted together: capture only, shift_cnt = 0 next cycle.
REQ-028 Strobes with all seg_cfg = 0: chain is SEGS bypass flops; update changes nothing.

Reset
REQ-029 RST high at a clock edge: sr = 0, ur = 0, byp = 0, seg_cfg = all ones, shift_cnt = 0; RST overrides all strobes.
REQ-030 After reset: s_data_out = 0, chain_len = WIDTH, p_data_out = p_data_in (mode 0) or 0 (mode 1).
REQ-031 RST asserted mid-shift SHALL discard partial data; first post-reset shift starts from cleared state.

Verification (WIDTH=8, SEGS=2)
REQ-032 Reset: RST 1 cycle, mode=1 -> p_data_out=8'h00, s_data_out=0, chain_len=8, shift_cnt=0.
REQ-033 Capture p_data_in=8'hA5, seg_en=2'b11, then 8 shifts with s_data_in=0 -> s_data_out before each shift 1,0,1,0,0,1,0,1; shift_cnt=8.
REQ-034 Shift in 0,0,1,1,1,1,0,0, update_dr, mode=1 -> p_data_out=8'h3C; mode=0 -> p_data_out follows p_data_in.
REQ-035 Capture p_data_in=8'hF0 with seg_en=2'b10 -> chain_len=5; shifting s_data_in=1 yields s_data_out 1,1,1,1,0, then 1 from 6th observation on; update leaves ur[3:0] unchanged.
REQ-036 capture_dr and shift_dr together -> captured value present, shift_cnt=0; RST raised after 3 shifts -> all state cleared per REQ-029.
REQ-037 Hold shift_dr for 65540 cycles -> shift_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/bsr_seg.sv
`default_nettype none
// ============================================================================
// Module      : bsr_seg
// Description : Segmented boundary-scan register; disabled segments collapse
//               to a single bypass flop, so chain length follows the config.
// Revision    : 1.0  initial release
// ============================================================================
module bsr_seg #(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4
) (
  input  logic             ICLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] p_data_in,
  output logic [WIDTH-1:0] p_data_out,
  input  logic             s_data_in,
  output logic             s_data_out,
  input  logic             mode,
  input  logic             capture_dr,
  input  logic             shift_dr,
  input  logic             update_dr,
  input  logic [SEGS-1:0]  seg_en,
  output logic [15:0]      chain_len,
  output logic [15:0]      shift_cnt
);

  localparam int c_SEG_W = WIDTH / SEGS;

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_ur;
  logic [SEGS-1:0]  r_byp;
  logic [SEGS-1:0]  r_seg_cfg;
  logic [15:0]      r_shift_cnt;

  logic [SEGS-1:0]  w_seg_in;
  logic [SEGS-1:0]  w_seg_out;
  logic [WIDTH-1:0] w_sr_sh;
  logic [SEGS-1:0]  w_byp_sh;
  logic [WIDTH-1:0] w_sr_cap;
  logic [SEGS-1:0]  w_byp_cap;
  logic [WIDTH-1:0] w_ur_upd;
  logic [15:0]      w_ones;

  // Serial path: each segment's output is its MSB cell or its bypass flop.
  always_comb begin
    w_seg_out = '0;
    w_seg_in  = '0;
    for (int k = 0; k < SEGS; k++) begin
      w_seg_out[k] = r_seg_cfg[k] ? r_sr[k*c_SEG_W + c_SEG_W - 1] : r_byp[k];
    end
    w_seg_in[0] = s_data_in;
    for (int k = 1; k < SEGS; k++) begin
      w_seg_in[k] = w_seg_out[k-1];
    end
  end

  always_comb begin
    w_sr_sh  = r_sr;
    w_byp_sh = r_byp;
    for (int k = 0; k < SEGS; k++) begin
      if (r_seg_cfg[k]) begin
        for (int j = c_SEG_W - 1; j > 0; j--) begin
          w_sr_sh[k*c_SEG_W + j] = r_sr[k*c_SEG_W + j - 1];
        end
        w_sr_sh[k*c_SEG_W] = w_seg_in[k];
      end else begin
        w_byp_sh[k] = w_seg_in[k];
      end
    end
  end

  // Capture uses the incoming seg_en, since it becomes the new topology.
  always_comb begin
    w_sr_cap  = r_sr;
    w_byp_cap = r_byp;
    w_ur_upd  = r_ur;
    for (int k = 0; k < SEGS; k++) begin
      if (!seg_en[k]) begin
        w_byp_cap[k] = 1'b0;
      end
      for (int j = 0; j < c_SEG_W; j++) begin
        if (seg_en[k]) begin
          w_sr_cap[k*c_SEG_W + j] = p_data_in[k*c_SEG_W + j];
        end
        if (r_seg_cfg[k]) begin
          w_ur_upd[k*c_SEG_W + j] = r_sr[k*c_SEG_W + j];
        end
      end
    end
  end

  always_comb begin
    w_ones = '0;
    for (int k = 0; k < SEGS; k++) begin
      w_ones = w_ones + 16'(r_seg_cfg[k]);
    end
  end

  always_ff @(posedge ICLK) begin
    if (RST) begin
      r_sr        <= '0;
      r_ur        <= '0;
      r_byp       <= '0;
      r_seg_cfg   <= '1;
      r_shift_cnt <= '0;
    end else if (capture_dr) begin
      r_seg_cfg   <= seg_en;
      r_sr        <= w_sr_cap;
      r_byp       <= w_byp_cap;
      r_shift_cnt <= '0;
    end else if (shift_dr) begin
      r_sr  <= w_sr_sh;
      r_byp <= w_byp_sh;
      if (r_shift_cnt != 16'hFFFF) begin
        r_shift_cnt <= r_shift_cnt + 16'd1;
      end
    end else if (update_dr) begin
      r_ur <= w_ur_upd;
    end
  end

  assign s_data_out = w_seg_out[SEGS-1];
  assign p_data_out = mode ? r_ur : p_data_in;
  assign chain_len  = w_ones * 16'(c_SEG_W) + (16'(SEGS) - w_ones);
  assign shift_cnt  = r_shift_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bsr_seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsr_seg
// Description : Directed self-checking bench for bsr_seg (WIDTH=8, SEGS=2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_bsr_seg;

  logic       ICLK;
  logic       RST;
  logic [7:0] p_data_in;
  logic [7:0] p_data_out;
  logic       s_data_in;
  logic       s_data_out;
  logic       mode;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic [1:0] seg_en;
  logic [15:0] chain_len;
  logic [15:0] shift_cnt;

  int n_total = 0;
  int n_bad   = 0;

  bsr_seg #(.WIDTH(8), .SEGS(2)) u_dut (
    .ICLK       (ICLK),
    .RST        (RST),
    .p_data_in  (p_data_in),
    .p_data_out (p_data_out),
    .s_data_in  (s_data_in),
    .s_data_out (s_data_out),
    .mode       (mode),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .seg_en     (seg_en),
    .chain_len  (chain_len),
    .shift_cnt  (shift_cnt)
  );

  initial ICLK = 1'b0;
  always #5 ICLK = ~ICLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ICLK);
    #1;
  endtask

  task automatic strobe_capture(input logic [7:0] d, input logic [1:0] en);
    p_data_in  = d;
    seg_en     = en;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
  endtask

  task automatic strobe_update();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    RST = 1'b1; p_data_in = '0; s_data_in = 1'b0; mode = 1'b1;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; seg_en = 2'b11;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_pout", 32'(p_data_out), 32'h00);
    chk("rst_sout", 32'(s_data_out), 32'h0);
    chk("rst_len",  32'(chain_len),  32'd8);
    chk("rst_cnt",  32'(shift_cnt),  32'd0);

    // Capture A5 and shift it out MSB first
    strobe_capture(8'hA5, 2'b11);
    v = 8'hA5;
    shift_dr = 1'b1; s_data_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_sout%0d", i), 32'(s_data_out), 32'(v[7-i]));
      tick();
    end
    shift_dr = 1'b0;
    chk("a5_cnt", 32'(shift_cnt), 32'd8);

    v = 8'b0011_1100;
    shift_dr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data_in = v[7-i];
      tick();
    end
    shift_dr = 1'b0;
    chk("3c_cnt", 32'(shift_cnt), 32'd16);
    strobe_update();
    mode = 1'b1; #1;
    chk("3c_pout", 32'(p_data_out), 32'h3C);
    mode = 1'b0; p_data_in = 8'h96; #1;
    chk("transp_96", 32'(p_data_out), 32'h96);
    p_data_in = 8'h21; #1;
    chk("transp_21", 32'(p_data_out), 32'h21);
    mode = 1'b1;

    // Segment 0 bypassed; seg_en change without capture must not matter
    strobe_capture(8'hF0, 2'b10);
    seg_en = 2'b11; #1;
    chk("byp_len", 32'(chain_len), 32'd5);
    shift_dr = 1'b1; s_data_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("byp_sout%0d", i), 32'(s_data_out), (i == 4) ? 32'h0 : 32'h1);
      tick();
    end
    shift_dr = 1'b0;
    strobe_update();
    chk("byp_pout", 32'(p_data_out), 32'hFC);

    // Capture wins over shift
    p_data_in = 8'h5A; seg_en = 2'b11; capture_dr = 1'b1; shift_dr = 1'b1;
    tick();
    capture_dr = 1'b0; shift_dr = 1'b0;
    chk("cs_cnt",  32'(shift_cnt),  32'd0);
    chk("cs_sout", 32'(s_data_out), 32'h0);
    chk("cs_len",  32'(chain_len),  32'd8);
    strobe_update();
    chk("cs_pout", 32'(p_data_out), 32'h5A);

    // Shift wins over update
    s_data_in = 1'b1; shift_dr = 1'b1; update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    chk("su_pout", 32'(p_data_out), 32'h5A);
    tick();
    tick();
    shift_dr = 1'b0;
    chk("mid_cnt",  32'(shift_cnt),  32'd3);
    chk("mid_sout", 32'(s_data_out), 32'h1);

    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst2_pout", 32'(p_data_out), 32'h00);
    chk("rst2_sout", 32'(s_data_out), 32'h0);
    chk("rst2_len",  32'(chain_len),  32'd8);
    chk("rst2_cnt",  32'(shift_cnt),  32'd0);
    shift_dr = 1'b1; s_data_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rst2_sout%0d", i), 32'(s_data_out), 32'h0);
      tick();
    end
    shift_dr = 1'b0;
    chk("rst2_cnt8", 32'(shift_cnt), 32'd8);

    // All segments bypassed: update must leave ur alone
    strobe_capture(8'hFF, 2'b11);
    strobe_update();
    chk("all_ff", 32'(p_data_out), 32'hFF);
    strobe_capture(8'h00, 2'b11);
    strobe_capture(8'h00, 2'b00);
    chk("none_len", 32'(chain_len), 32'd2);
    shift_dr = 1'b1; s_data_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("none_sout%0d", i), 32'(s_data_out), (i == 2) ? 32'h1 : 32'h0);
      tick();
    end
    shift_dr = 1'b0;
    strobe_update();
    chk("none_pout", 32'(p_data_out), 32'hFF);

    // Counter saturation
    strobe_capture(8'h00, 2'b11);
    shift_dr = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_ffff", 32'(shift_cnt), 32'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    shift_dr = 1'b0;
    chk("sat_hold", 32'(shift_cnt), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
